// File: rtl/comm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : comm_sched
//  Brief    : Command scheduler for the UART/SPI/I2C communication core.
//             Builds 3-nibble commands from the host bus, queues them in a
//             FIFO, dispatches them in order with a start/busy handshake and
//             per-transaction watchdogs, and returns captured read bytes to
//             the host as two nibbles.
//  Revision : 1.0 - initial release
// ============================================================================
module comm_sched #(
   parameter int FIFO_DEPTH   = 4,
   parameter int ACK_TIMEOUT  = 4,
   parameter int DONE_TIMEOUT = 4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] nib_in,
   input  logic       nib_valid,
   output logic       cmd_full,
   output logic       uart_start,
   output logic       spi_start,
   output logic       i2c_start,
   input  logic       uart_busy,
   input  logic       spi_busy,
   input  logic       i2c_busy,
   input  logic       i2c_error,
   output logic [7:0] tx_data,
   input  logic [7:0] spi_rx,
   input  logic [7:0] i2c_rx,
   output logic [3:0] nib_out,
   output logic       nib_out_valid,
   output logic       sched_busy,
   output logic       err_cmd,
   output logic       err_ack,
   output logic       err_done,
   output logic       err_i2c,
   output logic       ovf
);

   localparam int              c_aw        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              c_cw        = c_aw + 1;
   localparam logic [c_cw-1:0] c_depth     = c_cw'(FIFO_DEPTH);
   localparam logic [11:0]     c_ack_last  = 12'(ACK_TIMEOUT - 1);
   localparam logic [11:0]     c_done_to   = 12'(DONE_TIMEOUT);
   localparam logic [1:0]      c_tgt_uart  = 2'b00;
   localparam logic [1:0]      c_tgt_spi   = 2'b01;
   localparam logic [1:0]      c_tgt_i2c   = 2'b10;
   localparam logic [1:0]      c_tgt_rsvd  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RES_HI    = 3'd4,
      S_RES_LO    = 3'd5
   } state_t;

   // ---------------------------------------------------------------- assembler
   logic [1:0]  r_nib_cnt;
   logic [3:0]  r_opcode;
   logic [3:0]  r_pay_hi;
   logic        w_third;
   logic        w_cmd_bad;
   logic        w_push_req;
   logic [10:0] w_entry;

   assign w_third    = nib_valid && (r_nib_cnt == 2'd2);
   assign w_cmd_bad  = r_opcode[3] || (r_opcode[1:0] == c_tgt_rsvd);
   assign w_push_req = w_third && !w_cmd_bad;
   // Entry layout: {capture, target[1:0], payload[7:0]}
   assign w_entry    = {r_opcode[2], r_opcode[1:0], r_pay_hi, nib_in};

   // Nibble counter and opcode/high-payload capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nib_cnt <= 2'd0;
         r_opcode  <= 4'd0;
         r_pay_hi  <= 4'd0;
      end else if (nib_valid) begin
         case (r_nib_cnt)
            2'd0: begin
               r_opcode  <= nib_in;
               r_nib_cnt <= 2'd1;
            end
            2'd1: begin
               r_pay_hi  <= nib_in;
               r_nib_cnt <= 2'd2;
            end
            default: r_nib_cnt <= 2'd0;
         endcase
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [10:0]     r_mem [FIFO_DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_cw-1:0] r_count;
   logic [c_cw-1:0] w_count_next;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [10:0]     w_head;

   // Fullness is judged on the current count, so a same-cycle pop never
   // rescues a push into a full queue.
   assign w_full  = (r_count == c_depth);
   assign w_empty = (r_count == '0);
   assign w_push  = w_push_req && !w_full;
   assign w_head  = r_mem[r_rd_ptr];

   // Occupancy after this cycle's push/pop
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Queue storage; contents need no reset since the count gates all reads
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // Queue pointers and count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
      end
   end

   // ---------------------------------------------------------------- dispatcher
   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_cur_tgt;
   logic        r_cur_cap;
   logic [11:0] r_wd;
   logic [7:0]  r_result;
   logic        w_head_busy;
   logic        w_cur_busy;
   logic [7:0]  w_rx_byte;
   logic        w_ack_to;
   logic        w_done_to;
   logic        w_done_ok;

   // Busy of the engine addressed by the queue head
   always_comb begin
      w_head_busy = 1'b0;
      case (w_head[9:8])
         c_tgt_uart: w_head_busy = uart_busy;
         c_tgt_spi:  w_head_busy = spi_busy;
         c_tgt_i2c:  w_head_busy = i2c_busy;
         default:    w_head_busy = 1'b0;
      endcase
   end

   // Busy of the engine running the current transaction
   always_comb begin
      w_cur_busy = 1'b0;
      case (r_cur_tgt)
         c_tgt_uart: w_cur_busy = uart_busy;
         c_tgt_spi:  w_cur_busy = spi_busy;
         c_tgt_i2c:  w_cur_busy = i2c_busy;
         default:    w_cur_busy = 1'b0;
      endcase
   end

   // Read byte at busy fall; a NACKed I2C read returns 0xFF
   always_comb begin
      w_rx_byte = spi_rx;
      if (r_cur_tgt == c_tgt_i2c) begin
         w_rx_byte = i2c_error ? 8'hFF : i2c_rx;
      end
   end

   // Next-state logic, queue pop and watchdog decisions
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_ack_to     = 1'b0;
      w_done_to    = 1'b0;
      w_done_ok    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !w_head_busy) begin
               w_pop        = 1'b1;
               w_state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: w_state_next = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (w_cur_busy) begin
               w_state_next = S_WAIT_DONE;
            end else if (r_wd >= c_ack_last) begin
               w_ack_to     = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!w_cur_busy) begin
               w_done_ok = 1'b1;
               if (r_cur_cap && (r_cur_tgt != c_tgt_uart)) begin
                  w_state_next = S_RES_HI;
               end else begin
                  w_state_next = S_IDLE;
               end
            end else if (r_wd >= c_done_to) begin
               w_done_to    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_RES_HI: w_state_next = S_RES_LO;
         S_RES_LO: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // State register and saturating watchdog, restarted on every state entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wd    <= 12'd0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next != r_state) begin
            r_wd <= 12'd0;
         end else if (r_wd != 12'hFFF) begin
            r_wd <= r_wd + 12'd1;
         end
      end
   end

   // Transaction context: target, capture flag, payload and returned byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur_tgt <= 2'd0;
         r_cur_cap <= 1'b0;
         tx_data   <= 8'd0;
         r_result  <= 8'd0;
      end else begin
         if (w_pop) begin
            r_cur_tgt <= w_head[9:8];
            r_cur_cap <= w_head[10];
            tx_data   <= w_head[7:0];
         end
         if (w_done_ok) begin
            r_result <= w_rx_byte;
         end
      end
   end

   // Registered outputs: launch pulses, result nibbles, status and errors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart_start    <= 1'b0;
         spi_start     <= 1'b0;
         i2c_start     <= 1'b0;
         nib_out       <= 4'd0;
         nib_out_valid <= 1'b0;
         cmd_full      <= 1'b0;
         sched_busy    <= 1'b0;
         err_cmd       <= 1'b0;
         err_ack       <= 1'b0;
         err_done      <= 1'b0;
         err_i2c       <= 1'b0;
         ovf           <= 1'b0;
      end else begin
         uart_start <= w_pop && (w_head[9:8] == c_tgt_uart);
         spi_start  <= w_pop && (w_head[9:8] == c_tgt_spi);
         i2c_start  <= w_pop && (w_head[9:8] == c_tgt_i2c);

         nib_out       <= 4'd0;
         nib_out_valid <= 1'b0;
         if (w_state_next == S_RES_HI) begin
            nib_out       <= w_rx_byte[7:4];
            nib_out_valid <= 1'b1;
         end else if (w_state_next == S_RES_LO) begin
            nib_out       <= r_result[3:0];
            nib_out_valid <= 1'b1;
         end

         cmd_full   <= (w_count_next == c_depth);
         sched_busy <= (w_count_next != '0) || (w_state_next != S_IDLE);
         err_cmd    <= w_third && w_cmd_bad;
         err_ack    <= w_ack_to;
         err_done   <= w_done_to;
         err_i2c    <= w_done_ok && (r_cur_tgt == c_tgt_i2c) && i2c_error;
         ovf        <= ovf || (w_push_req && w_full);
      end
   end

endmodule
`default_nettype wire

// File: doc/comm_sched.md
# comm_sched

Command scheduler for the UART/SPI/I2C communication core. Assembles 3-nibble commands from the 4-bit host parallel bus and queues them in a small FIFO. Dispatches each command in order to its target engine using a start/busy handshake, with a watchdog on every transaction. Returns captured SPI/I2C read bytes to the host as two nibbles.

## Interface
- FIFO_DEPTH, 4: command queue entries; power of two, at least 2.
- ACK_TIMEOUT, 4: maximum cycles from start to engine busy rising.
- DONE_TIMEOUT, 4095: maximum cycles the engine may stay busy.

- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- nib_in  in  4  host command nibble.
- nib_valid  in  1  nib_in is valid this cycle.
- cmd_full  out  1  FIFO full.
- uart_start / spi_start / i2c_start  out  1 each  one-cycle launch pulse.
- uart_busy / spi_busy / i2c_busy  in  1 each  engine busy.
- i2c_error  in  1  I2C NACK, sampled when i2c_busy falls.
- tx_data  out  8  payload to the engine; stable from the start pulse until busy falls.
- spi_rx / i2c_rx  in  8 each  engine read byte, valid when busy falls.
- nib_out  out  4  result nibble.
- nib_out_valid  out  1  nib_out is valid.
- sched_busy  out  1  FIFO not empty, or FSM not in IDLE.
- err_cmd / err_ack / err_done / err_i2c  out  1 each  one-cycle error pulses.
- ovf  out  1  sticky FIFO overflow flag; cleared only by reset.

## Operation
- **Assembler.** A nibble counter counts 0→1→2→0 on each nib_valid.
  - Nibble 0 is the opcode: [1:0] target (00 UART, 01 SPI, 10 I2C, 11 reserved), [2] capture, [3] must be 0.
  - Nibbles 1 and 2 are the payload, high nibble then low nibble.
- **Push.** On the third nibble, the 11-bit entry {capture, target, payload} is pushed.
  - If the target is 11 or opcode[3] is 1, the entry is discarded and err_cmd pulses.
  - If the FIFO is full at push time, the entry is dropped and ovf is set. This holds even when a pop happens in the same cycle.
- **FSM states.** IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, RES_HI, RES_LO.
  - IDLE: if the FIFO is not empty and the head entry's target busy is 0, pop the entry, latch tx_data, go to LAUNCH. Otherwise stay. The queue is strictly in order; a busy head blocks the queue.
  - LAUNCH: the target's start is 1 for exactly this cycle. Go to WAIT_ACK.
  - WAIT_ACK: when busy is 1, go to WAIT_DONE. If busy is still 0 after ACK_TIMEOUT cycles, pulse err_ack and go to IDLE.
  - WAIT_DONE: when busy is 0, go to RES_HI if capture=1 and target≠UART, else IDLE.
    - For I2C, if i2c_error=1 on this edge, pulse err_i2c and substitute the result 0xFF.
    - If busy stays 1 for more than DONE_TIMEOUT cycles, pulse err_done and go to IDLE; no result is returned.
  - RES_HI: nib_out = result[7:4], nib_out_valid = 1. Go to RES_LO.
  - RES_LO: nib_out = result[3:0], nib_out_valid = 1. Go to IDLE.
- Capture on a UART command is ignored.
- The watchdog counters are 12 bits and saturating; they clear on each state entry.
- The FIFO is read/write pointer based with a count. Push and pop in the same cycle leave the count unchanged.

## Timing
- **Reset values.** All outputs are 0 (starts, tx_data, nib_out, nib_out_valid, cmd_full, sched_busy, all error pulses, ovf). The FSM is in IDLE, the nibble counter is 0, the FIFO is empty.
- **Reset mid-transaction.** Reset aborts immediately. Any start pulse is cut short and the queue is lost.
- **Dispatch latency.** Third nibble sampled at edge E0; entry visible after E0; pop at E1; start high from E1 to E2. Latency is 2 cycles, provided the engine is idle.
- **Back-to-back.** Next start no sooner than 2 cycles after busy falls (no capture) or 4 cycles (with capture).
- **Output registration.** All outputs are registered. There is no combinational path from nib_in or busy to any output.
- **Handshake gaps.** nib_valid gaps are allowed between nibbles; there is no inter-nibble timeout.

## Test plan
- Nibbles 0,A,5 with UART idle, busy high for 10 cycles -> uart_start pulses 2 cycles after the last nibble, tx_data=0xA5 throughout, no nib_out_valid.
- Nibbles 5,3,C; spi_busy held 20 cycles; spi_rx=0x9E -> spi_start, then nib_out 9 then E on consecutive cycles with nib_out_valid.
- Nibbles 6,0,1 (I2C capture) with i2c_error=1 at busy fall -> err_i2c pulse, nib_out F, F.
- Nibbles 3,x,x and 8,x,x -> err_cmd pulses twice, no start, sched_busy stays 0.
- Five commands pushed while SPI is held busy -> cmd_full=1 after the 4th, 5th dropped, ovf=1; four spi_starts follow in order once busy releases.
- Engine never raises busy -> err_ack after 4 cycles; busy stuck high -> err_done after 4095; reset asserted in WAIT_DONE -> all outputs 0 next cycle.
